// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer: FSM states, next-PC sources and
// the default reset vector. Also used by the optional branch statistics (BRANCH_STATS_EN).
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHalted = 2'd1,
    StStep   = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    SrcSeq,
    SrcBranch,
    SrcJump,
    SrcJr
  } pc_src_e;

  localparam logic [31:0] PcResetDefault = 32'h0000_0000;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Next-PC select: picks the fetch address for the selected source. Priority is
// resolved by the caller into the source enum.
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  pc_src_e               src_i,
  input  logic [DATA_WIDTH-1:0] pcplus4_i,
  input  logic [DATA_WIDTH-1:0] pcbranch_i,
  input  logic [DATA_WIDTH-1:0] pcjump_i,
  input  logic [DATA_WIDTH-1:0] pcjr_i,
  output logic [DATA_WIDTH-1:0] pc_next_o
);

  always_comb begin
    pc_next_o = pcplus4_i;
    unique case (src_i)
      SrcSeq:    pc_next_o = pcplus4_i;
      SrcBranch: pc_next_o = pcbranch_i;
      SrcJump:   pc_next_o = pcjump_i;
      SrcJr:     pc_next_o = pcjr_i;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencing with stall and debug halt/step/resume.
// Define BRANCH_STATS_EN to add saturating taken/not-taken/jump counters.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = DATA_WIDTH'(PcResetDefault)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_branch,
  input  logic                  i_bne,
  input  logic                  i_equal,
  input  logic                  i_jump,
  input  logic                  i_jr,
  input  logic [DATA_WIDTH-1:0] i_pcbranch,
  input  logic [DATA_WIDTH-1:0] i_pcjump,
  input  logic [DATA_WIDTH-1:0] i_pcjr,
  input  logic                  i_halt,
  input  logic                  i_step,
  input  logic                  i_resume,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pcplus4,
  output logic                  o_flush_ifid,
  output logic                  o_fetch_en,
  output logic                  o_halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           o_br_taken,
  output logic [31:0]           o_br_nottaken,
  output logic [31:0]           o_jumps
`endif
);

  seq_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_next;
  logic                  taken, active;
  pc_src_e               src;

  assign taken = i_branch & (i_equal ^ i_bne);

  always_comb begin
    src = SrcSeq;
    if (i_jr)        src = SrcJr;
    else if (i_jump) src = SrcJump;
    else if (taken)  src = SrcBranch;
  end

  assign o_pcplus4 = pc_q + DATA_WIDTH'(4);

  pc_next_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_next_mux (
    .src_i      (src),
    .pcplus4_i  (o_pcplus4),
    .pcbranch_i (i_pcbranch),
    .pcjump_i   (i_pcjump),
    .pcjr_i     (i_pcjr),
    .pc_next_o  (pc_next)
  );

  always_comb begin
    // A PC update resolves only in RUN or STEP, never while stalled or in reset.
    active  = ((state_q == StRun) || (state_q == StStep)) && !i_stall && !i_reset;
    state_d = state_q;
    unique case (state_q)
      StRun:    if (!i_stall && i_halt) state_d = StHalted;
      StHalted: begin
        if (i_resume)    state_d = StRun;
        else if (i_step) state_d = StStep;
      end
      StStep:   if (!i_stall) state_d = i_resume ? StRun : StHalted;
      default:  state_d = StRun;
    endcase
    pc_d = active ? pc_next : pc_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StRun;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_fetch_en   = active;
  assign o_flush_ifid = active && (src != SrcSeq);
  assign o_halted     = (state_q == StHalted);

`ifdef BRANCH_STATS_EN
  logic [31:0] br_taken_q, br_nottaken_q, jumps_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      br_taken_q    <= '0;
      br_nottaken_q <= '0;
      jumps_q       <= '0;
    end else if (active) begin
      if (src == SrcJr || src == SrcJump) jumps_q       <= sat_inc(jumps_q);
      else if (src == SrcBranch)          br_taken_q    <= sat_inc(br_taken_q);
      else if (i_branch)                  br_nottaken_q <= sat_inc(br_nottaken_q);
    end
  end

  assign o_br_taken    = br_taken_q;
  assign o_br_nottaken = br_nottaken_q;
  assign o_jumps       = jumps_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch, bne, equal, jump, jr, halt, step, resume;
  logic [31:0] pcbranch, pcjump, pcjr;
  logic [31:0] o_pc, o_pcplus4;
  logic        o_flush_ifid, o_fetch_en, o_halted;
`ifdef BRANCH_STATS_EN
  logic [31:0] o_br_taken, o_br_nottaken, o_jumps;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: current PC and debug mode.
  logic [31:0] m_pc = 32'h0;
  bit          m_halted = 1'b0;
  bit          m_stepping = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_stall      (stall),
    .i_branch     (branch),
    .i_bne        (bne),
    .i_equal      (equal),
    .i_jump       (jump),
    .i_jr         (jr),
    .i_pcbranch   (pcbranch),
    .i_pcjump     (pcjump),
    .i_pcjr       (pcjr),
    .i_halt       (halt),
    .i_step       (step),
    .i_resume     (resume),
    .o_pc         (o_pc),
    .o_pcplus4    (o_pcplus4),
    .o_flush_ifid (o_flush_ifid),
    .o_fetch_en   (o_fetch_en),
    .o_halted     (o_halted)
`ifdef BRANCH_STATS_EN
    ,
    .o_br_taken    (o_br_taken),
    .o_br_nottaken (o_br_nottaken),
    .o_jumps       (o_jumps)
`endif
  );

  function automatic bit m_taken();
    if (!branch) return 1'b0;
    return bne ? !equal : equal;
  endfunction

  function automatic bit m_active();
    return !reset && !stall && !m_halted;
  endfunction

  function automatic bit m_flush();
    return m_active() && (jr || jump || m_taken());
  endfunction

  function automatic logic [31:0] m_next_pc();
    if (reset) return 32'h0;
    if (!m_active()) return m_pc;
    if (jr) return pcjr;
    if (jump) return pcjump;
    if (m_taken()) return pcbranch;
    return m_pc + 32'd4;
  endfunction

  task automatic idle();
    {stall, branch, bne, equal, jump, jr, halt, step, resume} = '0;
    pcbranch = '0;
    pcjump = '0;
    pcjr = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    logic [31:0] npc;
    bit nh, ns;
    npc = m_next_pc();
    nh = m_halted;
    ns = m_stepping;
    if (reset) begin
      nh = 0; ns = 0;
    end else if (m_halted) begin
      if (resume) nh = 0;
      else if (step) begin nh = 0; ns = 1; end
    end else if (m_stepping) begin
      if (!stall) begin ns = 0; nh = !resume; end
    end else if (!stall && halt) begin
      nh = 1;
    end
    @(posedge clk);
    m_pc = npc;
    m_halted = nh;
    m_stepping = ns;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    jump = 1'b1; pcjump = 32'h0000_0800; branch = 1'b1; equal = 1'b1;
    tick();
    tick();
    settle();
    checks++;
    if (o_fetch_en !== 1'b0 || o_flush_ifid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: fetch_en=%b flush=%b want 0 0", o_fetch_en, o_flush_ifid);
    end
    checks++;
    if (o_pc !== 32'h0 || o_halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h halted=%b want 0 0", o_pc, o_halted);
    end
    idle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (o_pc !== 32'(4 * i) || o_flush_ifid !== 1'b0 || o_fetch_en !== 1'b1) begin
        errors++;
        $display("FAIL run_seq[%0d]: pc=%h flush=%b fetch=%b want %h 0 1", i, o_pc,
                 o_flush_ifid, o_fetch_en, 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_branches();
    // o_pc is now 0x10
    idle();
    branch = 1'b1; bne = 1'b1; equal = 1'b1; pcbranch = 32'h40;
    settle();
    checks++;
    if (o_pc !== 32'h10 || o_flush_ifid !== 1'b0) begin
      errors++;
      $display("FAIL bne_equal_flush: pc=%h flush=%b want 10 0", o_pc, o_flush_ifid);
    end
    tick();
    checks++;
    if (o_pc !== 32'h14) begin
      errors++;
      $display("FAIL bne_equal_pc: pc=%h want 14", o_pc);
    end
    bne = 1'b0;
    settle();
    checks++;
    if (o_flush_ifid !== 1'b1) begin
      errors++;
      $display("FAIL beq_taken_flush: flush=%b want 1", o_flush_ifid);
    end
    tick();
    checks++;
    if (o_pc !== 32'h40) begin
      errors++;
      $display("FAIL beq_taken_pc: pc=%h want 40", o_pc);
    end
    idle();
  endtask

  task automatic test_stall();
    idle();
    branch = 1'b1; equal = 1'b1; pcbranch = 32'h80; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (o_pc !== 32'h40 || o_flush_ifid !== 1'b0 || o_fetch_en !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: pc=%h flush=%b fetch=%b want 40 0 0", i, o_pc,
                 o_flush_ifid, o_fetch_en);
      end
      tick();
    end
    stall = 1'b0;
    settle();
    checks++;
    if (o_pc !== 32'h40 || o_flush_ifid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: pc=%h flush=%b want 40 1", o_pc, o_flush_ifid);
    end
    tick();
    checks++;
    if (o_pc !== 32'h80) begin
      errors++;
      $display("FAIL stall_redirect: pc=%h want 80", o_pc);
    end
    idle();
  endtask

  task automatic test_priority_wrap();
    idle();
    jr = 1'b1; pcjr = 32'h100; jump = 1'b1; pcjump = 32'h200;
    branch = 1'b1; equal = 1'b1; pcbranch = 32'h300;
    tick();
    checks++;
    if (o_pc !== 32'h100) begin
      errors++;
      $display("FAIL priority_jr: pc=%h want 100", o_pc);
    end
    jr = 1'b0;
    tick();
    checks++;
    if (o_pc !== 32'h200) begin
      errors++;
      $display("FAIL priority_jump: pc=%h want 200", o_pc);
    end
    idle();
    jump = 1'b1; pcjump = 32'hFFFF_FFFC;
    tick();
    idle();
    settle();
    checks++;
    if (o_pc !== 32'hFFFF_FFFC || o_pcplus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_plus4: pc=%h plus4=%h want fffffffc 0", o_pc, o_pcplus4);
    end
    tick();
    checks++;
    if (o_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h want 0", o_pc);
    end
  endtask

  task automatic test_halt_step();
    idle();
    jump = 1'b1; pcjump = 32'h20;
    tick();
    idle();
    halt = 1'b1;
    settle();
    checks++;
    if (o_pc !== 32'h20 || o_fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL halt_cycle: pc=%h fetch=%b want 20 1", o_pc, o_fetch_en);
    end
    tick();
    idle();
    branch = 1'b1; equal = 1'b1; pcbranch = 32'h99C; jump = 1'b1; pcjump = 32'h500;
    settle();
    checks++;
    if (o_halted !== 1'b1 || o_pc !== 32'h24 || o_fetch_en !== 1'b0 || o_flush_ifid !== 1'b0)
    begin
      errors++;
      $display("FAIL halted: halted=%b pc=%h fetch=%b flush=%b want 1 24 0 0", o_halted,
               o_pc, o_fetch_en, o_flush_ifid);
    end
    tick();
    idle();
    step = 1'b1;
    tick();
    idle();
    settle();
    checks++;
    if (o_halted !== 1'b0 || o_fetch_en !== 1'b1 || o_pc !== 32'h24) begin
      errors++;
      $display("FAIL step_state: halted=%b fetch=%b pc=%h want 0 1 24", o_halted,
               o_fetch_en, o_pc);
    end
    tick();
    checks++;
    if (o_pc !== 32'h28 || o_halted !== 1'b1) begin
      errors++;
      $display("FAIL step_done: pc=%h halted=%b want 28 1", o_pc, o_halted);
    end
    step = 1'b1;
    tick();
    idle();
    stall = 1'b1;
    settle();
    checks++;
    if (o_fetch_en !== 1'b0) begin
      errors++;
      $display("FAIL step_stall_fetch: fetch=%b want 0", o_fetch_en);
    end
    tick();
    stall = 1'b0;
    tick();
    checks++;
    if (o_pc !== 32'h2C || o_halted !== 1'b1) begin
      errors++;
      $display("FAIL step_after_stall: pc=%h halted=%b want 2c 1", o_pc, o_halted);
    end
    step = 1'b1; resume = 1'b1;
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (o_pc !== 32'h34 || o_halted !== 1'b0) begin
      errors++;
      $display("FAIL step_resume_race: pc=%h halted=%b want 34 0", o_pc, o_halted);
    end
    halt = 1'b1;
    tick();
    idle();
    resume = 1'b1;
    tick();
    idle();
    tick();
    checks++;
    if (o_pc !== 32'h3C || o_halted !== 1'b0) begin
      errors++;
      $display("FAIL resume: pc=%h halted=%b want 3c 0", o_pc, o_halted);
    end
    halt = 1'b1;
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    checks++;
    if (o_pc !== 32'h0 || o_halted !== 1'b0 || o_fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_from_halt: pc=%h halted=%b fetch=%b want 0 0 1", o_pc, o_halted,
               o_fetch_en);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle();
      reset    = ($urandom_range(0, 49) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      branch   = ($urandom_range(0, 2) == 0);
      bne      = $urandom_range(0, 1) != 0;
      equal    = $urandom_range(0, 1) != 0;
      jump     = ($urandom_range(0, 9) == 0);
      jr       = ($urandom_range(0, 9) == 0);
      halt     = ($urandom_range(0, 19) == 0);
      step     = ($urandom_range(0, 4) == 0);
      resume   = ($urandom_range(0, 9) == 0);
      pcbranch = $urandom() & 32'hFFFF_FFFC;
      pcjump   = $urandom() & 32'hFFFF_FFFC;
      pcjr     = $urandom() & 32'hFFFF_FFFC;
      settle();
      checks++;
      if (o_pc !== m_pc || o_pcplus4 !== m_pc + 32'd4) begin
        errors++;
        $display("FAIL rand_pc[%0d]: pc=%h plus4=%h want %h %h", i, o_pc, o_pcplus4, m_pc,
                 m_pc + 32'd4);
      end
      checks++;
      if (o_flush_ifid !== m_flush() || o_fetch_en !== m_active() || o_halted !== m_halted)
      begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: flush=%b fetch=%b halted=%b want %b %b %b", i,
                 o_flush_ifid, o_fetch_en, o_halted, m_flush(), m_active(), m_halted);
      end
      tick();
    end
    idle();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    idle();
    reset = 1'b1;
    tick();
    idle();
    branch = 1'b1; equal = 1'b1; pcbranch = 32'h60; stall = 1'b1;
    tick();
    stall = 1'b0;
    tick();
    bne = 1'b1;
    tick();
    bne = 1'b0; pcbranch = 32'h90;
    tick();
    idle();
    jump = 1'b1; pcjump = 32'h200;
    tick();
    idle();
    settle();
    checks++;
    if (o_br_taken !== 32'd2 || o_br_nottaken !== 32'd1 || o_jumps !== 32'd1) begin
      errors++;
      $display("FAIL stats: taken=%0d nottaken=%0d jumps=%0d want 2 1 1", o_br_taken,
               o_br_nottaken, o_jumps);
    end
  endtask
`endif

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_branches();
    test_stall();
    test_priority_wrap();
    test_halt_step();
    test_random();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the program counter and selects the next-PC source each cycle: sequential fetch, a taken conditional branch (target from the decode-stage branch adder), a jump, or a register jump. It sits between the fetch stage and the decode stage and drives the instruction-memory address and the IF/ID flush. It also obeys the hazard unit's stall and the debug unit's halt/step controls.

## Interface
- DATA_WIDTH, 32: PC and address width.
- PC_RESET, 0: PC value after reset.
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_stall  in  1  hazard-unit stall; hold PC.
- i_branch  in  1  decode holds a BEQ/BNE.
- i_bne  in  1  1 = BNE, 0 = BEQ; valid with i_branch.
- i_equal  in  1  decode-stage register compare, rs == rt.
- i_jump  in  1  decode holds J/JAL.
- i_jr  in  1  decode holds JR/JALR.
- i_pcbranch  in  DATA_WIDTH  branch target from the decode adder.
- i_pcjump  in  DATA_WIDTH  jump target.
- i_pcjr  in  DATA_WIDTH  register-jump target.
- i_halt  in  1  debug halt request / HALT instruction decoded.
- i_step  in  1  debug single-step pulse, honoured only while halted.
- i_resume  in  1  debug resume, honoured only while halted.
- o_pc  out  DATA_WIDTH  current fetch address.
- o_pcplus4  out  DATA_WIDTH  o_pc + 4.
- o_flush_ifid  out  1  squash the instruction currently being fetched.
- o_fetch_en  out  1  the IF/ID register may load.
- o_halted  out  1  sequencer is in HALTED.

## Operation
- **States:** RUN, HALTED, STEP.
- **Taken branch:** `taken = i_branch & (i_equal ^ i_bne)`.
- **Next-PC priority in RUN, with i_stall = 0:**
  - i_jr → i_pcjr.
  - else i_jump → i_pcjump.
  - else taken → i_pcbranch.
  - else o_pc + 4.
- **Flush:** asserted combinationally in the same cycle as the redirect, so IF/ID loads a bubble. There is no delay slot.
- **Arithmetic:** all PC arithmetic is modulo 2^DATA_WIDTH. 0xFFFFFFFC + 4 = 0x00000000.
- **Stall:** o_pc holds, o_fetch_en = 0, o_flush_ifid = 0.
  - A branch or jump present during the stall is not latched.
  - Decode re-presents it after the stall and it is evaluated then.
- **RUN → HALTED** on i_halt with i_stall = 0. The PC still advances or redirects on that cycle.
- **HALTED:**
  - o_pc holds; o_fetch_en = 0; o_halted = 1.
  - Branch, jump and stall inputs are ignored.
- **HALTED → STEP** on i_step.
- **STEP:**
  - Performs exactly one RUN-style update, including redirect and flush.
  - Then returns to HALTED, unless i_resume is also high, in which case it goes to RUN.
  - If i_stall is high in STEP, it waits in STEP.
- **HALTED → RUN** on i_resume. If i_step and i_resume are simultaneous, i_resume wins.
- **i_halt in STEP** is ignored; the sequencer re-halts after the step anyway.
- **Reset has priority over everything:**
  - State = RUN, o_pc = PC_RESET.
  - o_flush_ifid = 0, o_fetch_en = 0, o_halted = 0.
  - Reset mid-halt or mid-step discards that state.

## Timing
- The PC register updates on the rising edge of i_clk.
- A redirect decided in cycle N makes o_pc = target in cycle N+1.
- Outputs:
  - o_pcplus4 and o_flush_ifid are combinational from the registered o_pc, the state and the decode inputs.
  - o_halted is registered.
  - o_fetch_en = (state RUN, or STEP with no stall) & ~i_stall & ~i_reset.
- The first fetch after reset is at PC_RESET in the cycle after i_reset deasserts.

## Configuration
- **BRANCH_STATS_EN defined:**
  - Adds 32-bit saturating counters o_br_taken, o_br_nottaken and o_jumps.
  - A counter increments once per resolved (non-stalled, non-halted) event.
  - Counters clear on reset.
- **Undefined:** these ports and counters are absent and the behaviour is otherwise identical.

## Structure
- The shared package holds:
  - the state encoding (RUN = 2'd0, HALTED = 2'd1, STEP = 2'd2);
  - the next-PC source enum (SEQ, BRANCH, JUMP, JR);
  - the PC_RESET default.
- One sub-module, pc_next_mux: a combinational priority select from the source enum and the targets. The FSM, the PC register and the counters stay in the top.

## Test plan
- **Reset then run:** after reset, release with no control inputs → o_pc = 0, 4, 8, 12 on consecutive cycles; flush stays 0.
- **Branches:**
  - BEQ, i_equal = 1, i_pcbranch = 0x40, at o_pc = 0x10 → flush = 1 that cycle; next o_pc = 0x40.
  - BNE with i_equal = 1 → no flush; next o_pc = 0x14.
- **Stall:** 3-cycle stall with a taken branch present → o_pc frozen and flush = 0 for 3 cycles; the redirect happens on the first unstalled cycle.
- **Priority and wrap:**
  - i_jr, i_jump and taken branch together → next o_pc = i_pcjr.
  - o_pc = 0xFFFFFFFC with no control → next o_pc = 0.
- **Halt/step/resume:**
  - i_halt at o_pc = 0x20 → o_halted = 1 with o_pc held at 0x24.
  - i_step → one advance to 0x28, then halted again.
  - i_resume → sequential fetch resumes.
  - Reset asserted while halted → RUN at PC_RESET.
- **BRANCH_STATS_EN:** 2 taken, 1 not-taken and 1 jump, including one stalled occurrence → counters read 2, 1, 1.
